ceespu_mem_arbiter: RTL and testbench
=====================================

Name: ceespu_mem_arbiter

Overview:
- Shares one single-port synchronous RAM among three requesters: the ceespu instruction fetch port, the ceespu data port, and an external port (boot loader / debug DMA).
- Sits between the ceespu top and the RAM macro.
- Generates the CPU's instruction-side and data-side busy (stall) signals.
- Routes 1-cycle-latency read data back to whichever requester issued the read.

Parameters:
ADDR_W, 16, byte address width on all ports
MAX_WAIT, 15, max cycles a pending external request waits before CPU ports are forced busy

Ports:
I_clk  in  1  clock
I_rst  in  1  synchronous active-high reset
I_iReq  in  1  instruction fetch request (ceespu O_imemEnable)
I_iAddr  in  ADDR_W  fetch byte address, word aligned
O_iData  out  32  fetched word
O_iBusy  out  1  fetch not accepted this cycle
I_dE  in  1  data access request
I_dWe  in  4  byte write enables; 0 means read
I_dAddr  in  ADDR_W  data byte address
I_dWData  in  32  store data
O_dData  out  32  load data
O_dBusy  out  1  data access not accepted this cycle (ceespu I_dmemBusy)
I_xReq  in  1  external port requests ownership; held high for the whole burst
I_xWe  in  4  external byte write enables
I_xAddr  in  ADDR_W  external byte address
I_xWData  in  32  external write data
O_xGnt  out  1  external port owns RAM this cycle
O_xData  out  32  external read data
O_xValid  out  1  O_xData valid (one cycle after a granted read)
O_memE  out  1  RAM enable
O_memWe  out  4  RAM byte write enables
O_memAddr  out  ADDR_W-2  RAM word address
O_memWData  out  32  RAM write data
I_memData  in  32  RAM read data, valid one cycle after O_memE with O_memWe==0

Behaviour:
- Interface fixed: single clock I_clk; I_rst synchronous, active-high.
- Reset values:
  - state=CPU, wait counter=0, return tag=NONE.
  - O_memE=0, O_memWe=0, O_xGnt=0, O_xValid=0, O_iBusy=0, O_dBusy=0.
  - O_iData, O_dData, O_xData = 0.
- Reset mid-burst aborts the external grant immediately. No RAM write issues in the reset cycle.
- States: CPU, DRAIN, XOWN.
- CPU state, RAM access per cycle in fixed priority data > instruction:
  - I_dE=1: data access issued; O_dBusy=0.
  - I_dE=1 with I_iReq=1: O_iBusy=1 and the fetch retries next cycle.
  - I_dE=0, I_iReq=1: fetch issued; O_iBusy=0.
- Return tag: registered each cycle as D, I or NONE, set only for reads (write cycles register NONE).
  - Tag D: O_dData <= I_memData.
  - Tag I: O_iData <= I_memData.
  - The port not selected holds its last value.
- Wait counter:
  - Increments each CPU-state cycle with I_xReq=1; saturates at MAX_WAIT.
  - Clears whenever I_xReq=0 or on leaving CPU.
- CPU -> DRAIN when I_xReq=1 and (no CPU request this cycle, or counter==MAX_WAIT).
  - Leave-transition cycle: no CPU access issued; O_iBusy=O_dBusy=1 for any pending request.
- DRAIN (exactly 1 cycle):
  - No RAM access.
  - Completes the return of any outstanding CPU read.
  - Both CPU busies=1.
  - Next state XOWN.
- XOWN:
  - O_xGnt=1; RAM driven directly from the x-port (O_memE=1, O_memWe=I_xWe).
  - CPU busies=1 whenever their request is high.
  - Read (I_xWe=0): O_xValid=1 next cycle with O_xData=I_memData.
  - I_xReq=0: RAM idle that cycle, next state CPU, O_xGnt=0 in that cycle.
- I_xReq dropping while in DRAIN: state returns to CPU with no grant.
- Address mapping: O_memAddr = addr[ADDR_W-1:2]; low two bits ignored.
- Writes return nothing; tag NONE, no valid.
- Busy outputs are combinational from state and requests, so the CPU stalls in the same cycle.

Decomposition:
- Shared package ceespu_pkg holds:
  - arbiter state encoding (CPU=2'd0, DRAIN=2'd1, XOWN=2'd2);
  - return tag encoding (NONE=2'd0, I=2'd1, D=2'd2).
- One natural sub-module: ceespu_arb_wait_counter (saturating counter with clear and terminal-count flag).
- Everything else stays in the top module.

Test Plan:
- Reset with all requests high for 2 cycles -> O_memE=0, O_xGnt=0, busies 0 during reset. After release, fetch from 0x0004 issues with O_memAddr=1.
- I_iReq=1 @0x0010 and I_dE=1 read @0x0100 in the same cycle:
  - first cycle: O_memAddr=0x40, O_iBusy=1, O_dBusy=0;
  - next cycle: fetch issued, O_dData=RAM[0x40];
  - following cycle: O_iData=RAM[0x4].
- Data store 0xDEADBEEF, we=4'b0011 @0x0020, then load @0x0020 -> O_dData=0x0000BEEF (prior RAM=0), no O_iData update on the store.
- I_xReq=1 while CPU idle:
  - state sequence DRAIN then XOWN (O_xGnt high on 2nd cycle after request);
  - external write 0x12345678 @0x0040 then read @0x0040 -> O_xValid=1 with 0x12345678;
  - drop I_xReq -> CPU fetch accepted the following cycle.
- I_xReq=1 with CPU fetching every cycle, MAX_WAIT=15 -> fetches served 15 cycles, then O_iBusy=1, DRAIN, XOWN.
- Assert I_rst during XOWN with I_xWe=4'hF -> no RAM write that cycle, O_xGnt=0 next cycle, state CPU.

Source files
------------

// File: rtl/ceespu_pkg.sv
// rtl/ceespu_pkg.sv - shared encodings for the ceespu memory arbiter
package ceespu_pkg;

  typedef enum logic [1:0] {
    ST_CPU   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_XOWN  = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_I    = 2'd1,
    TAG_D    = 2'd2
  } ret_tag_t;

endpackage

// File: rtl/ceespu_arb_wait_counter.sv
// rtl/ceespu_arb_wait_counter.sv - saturating wait counter with clear and terminal-count flag
module ceespu_arb_wait_counter #(
  parameter int MAX = 15,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic tc
);

  logic [W-1:0] count;

  assign tc = (count == W'(MAX));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && !tc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ceespu_mem_arbiter.sv
// rtl/ceespu_mem_arbiter.sv - shares one single-port RAM between ceespu fetch, data and external ports
module ceespu_mem_arbiter
  import ceespu_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic              I_clk,
  input  logic              I_rst,
  input  logic              I_iReq,
  input  logic [ADDR_W-1:0] I_iAddr,
  output logic [31:0]       O_iData,
  output logic              O_iBusy,
  input  logic              I_dE,
  input  logic [3:0]        I_dWe,
  input  logic [ADDR_W-1:0] I_dAddr,
  input  logic [31:0]       I_dWData,
  output logic [31:0]       O_dData,
  output logic              O_dBusy,
  input  logic              I_xReq,
  input  logic [3:0]        I_xWe,
  input  logic [ADDR_W-1:0] I_xAddr,
  input  logic [31:0]       I_xWData,
  output logic              O_xGnt,
  output logic [31:0]       O_xData,
  output logic              O_xValid,
  output logic              O_memE,
  output logic [3:0]        O_memWe,
  output logic [ADDR_W-3:0] O_memAddr,
  output logic [31:0]       O_memWData,
  input  logic [31:0]       I_memData
);

  arb_state_t state;
  ret_tag_t   tag;
  ret_tag_t   tag_nxt;
  logic       x_pend;
  logic       x_rd;
  logic       in_cpu;
  logic       cpu_req;
  logic       tc;
  logic       leave;
  logic       unused_addr_lsbs;

  assign unused_addr_lsbs = ^{I_iAddr[1:0], I_dAddr[1:0], I_xAddr[1:0]};

  assign in_cpu  = (state == ST_CPU);
  assign cpu_req = I_dE | I_iReq;
  // Hand over when the CPU is idle, or when the external port has starved long enough.
  assign leave   = in_cpu & I_xReq & (~cpu_req | tc);

  ceespu_arb_wait_counter #(
    .MAX(MAX_WAIT)
  ) u_wait (
    .clk(I_clk),
    .rst(I_rst),
    .inc(in_cpu & I_xReq),
    .clr(~I_xReq | ~in_cpu | leave),
    .tc (tc)
  );

  always_comb begin
    O_memE     = 1'b0;
    O_memWe    = 4'h0;
    O_memAddr  = '0;
    O_memWData = 32'h0;
    O_iBusy    = 1'b0;
    O_dBusy    = 1'b0;
    O_xGnt     = 1'b0;
    tag_nxt    = TAG_NONE;
    x_rd       = 1'b0;
    if (!I_rst) begin
      case (state)
        ST_CPU: begin
          if (leave) begin
            O_iBusy = I_iReq;
            O_dBusy = I_dE;
          end else if (I_dE) begin
            O_memE     = 1'b1;
            O_memWe    = I_dWe;
            O_memAddr  = I_dAddr[ADDR_W-1:2];
            O_memWData = I_dWData;
            O_iBusy    = I_iReq;
            tag_nxt    = (I_dWe == 4'h0) ? TAG_D : TAG_NONE;
          end else if (I_iReq) begin
            O_memE    = 1'b1;
            O_memAddr = I_iAddr[ADDR_W-1:2];
            tag_nxt   = TAG_I;
          end
        end
        ST_DRAIN: begin
          O_iBusy = 1'b1;
          O_dBusy = 1'b1;
        end
        ST_XOWN: begin
          O_iBusy = I_iReq;
          O_dBusy = I_dE;
          if (I_xReq) begin
            O_xGnt     = 1'b1;
            O_memE     = 1'b1;
            O_memWe    = I_xWe;
            O_memAddr  = I_xAddr[ADDR_W-1:2];
            O_memWData = I_xWData;
            x_rd       = (I_xWe == 4'h0);
          end
        end
        default: begin
          O_iBusy = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state    <= ST_CPU;
      tag      <= TAG_NONE;
      x_pend   <= 1'b0;
      O_iData  <= 32'h0;
      O_dData  <= 32'h0;
      O_xData  <= 32'h0;
      O_xValid <= 1'b0;
    end else begin
      case (state)
        ST_CPU:   if (leave) state <= ST_DRAIN;
        ST_DRAIN: state <= I_xReq ? ST_XOWN : ST_CPU;
        ST_XOWN:  if (!I_xReq) state <= ST_CPU;
        default:  state <= ST_CPU;
      endcase
      tag    <= tag_nxt;
      x_pend <= x_rd;
      // RAM data arrives one cycle after issue; route it by the tag captured at issue.
      if (tag == TAG_D) O_dData <= I_memData;
      if (tag == TAG_I) O_iData <= I_memData;
      O_xValid <= x_pend;
      if (x_pend) O_xData <= I_memData;
    end
  end

endmodule

// File: tb/tb_ceespu_mem_arbiter.sv
// tb/tb_ceespu_mem_arbiter.sv - randomized self-checking bench for ceespu_mem_arbiter
module tb_ceespu_mem_arbiter;

  localparam int ADDR_W   = 16;
  localparam int MAX_WAIT = 15;
  localparam int WORDS    = 1 << (ADDR_W - 2);

  logic              I_clk = 1'b0;
  logic              I_rst;
  logic              I_iReq;
  logic [ADDR_W-1:0] I_iAddr;
  logic [31:0]       O_iData;
  logic              O_iBusy;
  logic              I_dE;
  logic [3:0]        I_dWe;
  logic [ADDR_W-1:0] I_dAddr;
  logic [31:0]       I_dWData;
  logic [31:0]       O_dData;
  logic              O_dBusy;
  logic              I_xReq;
  logic [3:0]        I_xWe;
  logic [ADDR_W-1:0] I_xAddr;
  logic [31:0]       I_xWData;
  logic              O_xGnt;
  logic [31:0]       O_xData;
  logic              O_xValid;
  logic              O_memE;
  logic [3:0]        O_memWe;
  logic [ADDR_W-3:0] O_memAddr;
  logic [31:0]       O_memWData;
  logic [31:0]       I_memData;

  always #5 I_clk = ~I_clk;

  ceespu_mem_arbiter #(
    .ADDR_W  (ADDR_W),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .I_clk     (I_clk),
    .I_rst     (I_rst),
    .I_iReq    (I_iReq),
    .I_iAddr   (I_iAddr),
    .O_iData   (O_iData),
    .O_iBusy   (O_iBusy),
    .I_dE      (I_dE),
    .I_dWe     (I_dWe),
    .I_dAddr   (I_dAddr),
    .I_dWData  (I_dWData),
    .O_dData   (O_dData),
    .O_dBusy   (O_dBusy),
    .I_xReq    (I_xReq),
    .I_xWe     (I_xWe),
    .I_xAddr   (I_xAddr),
    .I_xWData  (I_xWData),
    .O_xGnt    (O_xGnt),
    .O_xData   (O_xData),
    .O_xValid  (O_xValid),
    .O_memE    (O_memE),
    .O_memWe   (O_memWe),
    .O_memAddr (O_memAddr),
    .O_memWData(O_memWData),
    .I_memData (I_memData)
  );

  // RAM macro stand-in: synchronous, one-cycle read latency, byte-write enables
  logic [31:0] ram [WORDS];
  always @(posedge I_clk) begin
    if (O_memE) begin
      if (O_memWe == 4'h0) I_memData <= ram[O_memAddr];
      else
        for (int b = 0; b < 4; b++)
          if (O_memWe[b]) ram[O_memAddr][8*b +: 8] <= O_memWData[8*b +: 8];
    end
  end

  // Reference model: owner phase, starvation count, shadow memory, scheduled returns
  typedef struct {
    int          due;
    int          kind;
    logic [31:0] val;
  } ret_t;

  logic [31:0] ref_mem [WORDS];
  ret_t        pend [$];
  int          mode;
  int          wcnt;
  int          cyc;
  bit          regs_known;
  logic [31:0] exp_i, exp_d, exp_x;
  bit          exp_xv;
  int          checks;
  int          errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d got %h exp %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [ADDR_W-1:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return ADDR_W'($urandom);
    return ADDR_W'($urandom_range(0, 255));
  endfunction

  task automatic set_in(input logic rst, input logic ir, input logic [15:0] ia,
                        input logic de, input logic [3:0] dwe, input logic [15:0] da,
                        input logic [31:0] dwd, input logic xr, input logic [3:0] xwe,
                        input logic [15:0] xa, input logic [31:0] xwd);
    I_rst = rst;  I_iReq = ir;  I_iAddr = ia;
    I_dE = de;    I_dWe = dwe;  I_dAddr = da;  I_dWData = dwd;
    I_xReq = xr;  I_xWe = xwe;  I_xAddr = xa;  I_xWData = xwd;
  endtask

  task automatic idle();
    set_in(1'b0, 1'b0, 16'h0, 1'b0, 4'h0, 16'h0, 32'h0, 1'b0, 4'h0, 16'h0, 32'h0);
  endtask

  // Called on a falling edge with inputs applied; checks this cycle, advances the model
  task automatic step();
    logic              e_ib, e_db, e_gnt;
    logic [3:0]        e_we;
    logic [ADDR_W-3:0] e_a;
    logic [31:0]       e_wd;
    int                acc;
    bit                go;
    ret_t              r;
    #1;
    exp_xv = 1'b0;
    while (pend.size() > 0 && pend[0].due == cyc) begin
      r = pend.pop_front();
      case (r.kind)
        1:       exp_i = r.val;
        2:       exp_d = r.val;
        default: begin exp_x = r.val; exp_xv = 1'b1; end
      endcase
    end
    e_ib = 0; e_db = 0; e_gnt = 0; e_we = 0; e_a = '0; e_wd = 0; acc = 0; go = 0;
    if (!I_rst) begin
      case (mode)
        0: begin
          go = I_xReq && (!(I_dE || I_iReq) || wcnt == MAX_WAIT);
          if (go) begin
            e_ib = I_iReq; e_db = I_dE;
          end else if (I_dE) begin
            acc = (I_dWe == 4'h0) ? 2 : 4;
            e_a = I_dAddr[ADDR_W-1:2]; e_we = I_dWe; e_wd = I_dWData; e_ib = I_iReq;
          end else if (I_iReq) begin
            acc = 1; e_a = I_iAddr[ADDR_W-1:2];
          end
        end
        1: begin e_ib = 1; e_db = 1; end
        default: begin
          e_ib = I_iReq; e_db = I_dE;
          if (I_xReq) begin
            e_gnt = 1;
            acc = (I_xWe == 4'h0) ? 3 : 4;
            e_a = I_xAddr[ADDR_W-1:2]; e_we = I_xWe; e_wd = I_xWData;
          end
        end
      endcase
    end
    check("mem_e", 32'(O_memE), 32'(acc != 0));
    check("mem_we", 32'(O_memWe), 32'(e_we));
    if (acc != 0) check("mem_addr", 32'(O_memAddr), 32'(e_a));
    if (acc == 4) check("mem_wdata", O_memWData, e_wd);
    check("i_busy", 32'(O_iBusy), 32'(e_ib));
    check("d_busy", 32'(O_dBusy), 32'(e_db));
    check("x_gnt", 32'(O_xGnt), 32'(e_gnt));
    if (regs_known) begin
      check("i_data", O_iData, exp_i);
      check("d_data", O_dData, exp_d);
      check("x_valid", 32'(O_xValid), 32'(exp_xv));
      check("x_data", O_xData, exp_x);
    end
    if (acc == 4) ref_mem[e_a] = merge(ref_mem[e_a], e_wd, e_we);
    else if (acc != 0) pend.push_back('{cyc + 2, acc, ref_mem[e_a]});
    if (I_rst) begin
      mode = 0; wcnt = 0; pend.delete();
      exp_i = 0; exp_d = 0; exp_x = 0; regs_known = 1;
    end else begin
      case (mode)
        0: begin
          if (go) begin mode = 1; wcnt = 0; end
          else if (!I_xReq) wcnt = 0;
          else if (wcnt < MAX_WAIT) wcnt++;
        end
        1: mode = I_xReq ? 2 : 0;
        default: if (!I_xReq) mode = 0;
      endcase
    end
    cyc++;
    @(negedge I_clk);
  endtask

  initial begin
    logic xr;
    checks = 0; errors = 0; cyc = 0; mode = 0; wcnt = 0; regs_known = 0;
    exp_i = 0; exp_d = 0; exp_x = 0; exp_xv = 0;
    I_memData = 32'h0;
    for (int k = 0; k < WORDS; k++) begin
      ram[k]     = (k >= 8 && k < 32) ? 32'h0 : 32'(k) * 32'h9E3779B1;
      ref_mem[k] = (k >= 8 && k < 32) ? 32'h0 : 32'(k) * 32'h9E3779B1;
    end
    @(negedge I_clk);

    // reset with every requester active
    repeat (2) begin
      set_in(1'b1, 1'b1, 16'h4, 1'b1, 4'h0, 16'h8, 32'h0, 1'b1, 4'hF, 16'h40, 32'hFFFFFFFF);
      step();
    end
    set_in(1'b0, 1'b1, 16'h0004, 1'b0, 4'h0, 16'h0, 32'h0, 1'b0, 4'h0, 16'h0, 32'h0);
    step();
    idle(); step();

    // simultaneous fetch and load: data wins, fetch retries
    set_in(1'b0, 1'b1, 16'h0010, 1'b1, 4'h0, 16'h0100, 32'h0, 1'b0, 4'h0, 16'h0, 32'h0);
    step();
    set_in(1'b0, 1'b1, 16'h0010, 1'b0, 4'h0, 16'h0, 32'h0, 1'b0, 4'h0, 16'h0, 32'h0);
    step();
    idle(); step(); step();

    // partial store then load back
    set_in(1'b0, 1'b0, 16'h0, 1'b1, 4'b0011, 16'h0020, 32'hDEADBEEF, 1'b0, 4'h0, 16'h0, 32'h0);
    step();
    set_in(1'b0, 1'b0, 16'h0, 1'b1, 4'h0, 16'h0020, 32'h0, 1'b0, 4'h0, 16'h0, 32'h0);
    step();
    idle(); step(); step();

    // external burst while CPU idle: write, read, release
    repeat (3) begin
      set_in(1'b0, 1'b0, 16'h0, 1'b0, 4'h0, 16'h0, 32'h0, 1'b1, 4'hF, 16'h0040, 32'h12345678);
      step();
    end
    repeat (2) begin
      set_in(1'b0, 1'b0, 16'h0, 1'b0, 4'h0, 16'h0, 32'h0, 1'b1, 4'h0, 16'h0040, 32'h0);
      step();
    end
    set_in(1'b0, 1'b1, 16'h0040, 1'b0, 4'h0, 16'h0, 32'h0, 1'b0, 4'h0, 16'h0, 32'h0);
    step();
    idle(); step(); step();

    // external request against a continuous fetch stream: starvation limit
    for (int i = 0; i < 22; i++) begin
      set_in(1'b0, 1'b1, 16'(i * 4), 1'b0, 4'h0, 16'h0, 32'h0, 1'b1, 4'h0, 16'h0044, 32'h0);
      step();
    end
    idle(); step(); step();

    // reset during ownership with a full write pending
    repeat (2) begin
      set_in(1'b0, 1'b0, 16'h0, 1'b0, 4'h0, 16'h0, 32'h0, 1'b1, 4'h0, 16'h0048, 32'h0);
      step();
    end
    set_in(1'b1, 1'b0, 16'h0, 1'b0, 4'h0, 16'h0, 32'h0, 1'b1, 4'hF, 16'h0048, 32'hCAFEF00D);
    step();
    set_in(1'b0, 1'b0, 16'h0, 1'b0, 4'h0, 16'h0, 32'h0, 1'b1, 4'hF, 16'h0048, 32'hCAFEF00D);
    step();
    set_in(1'b0, 1'b0, 16'h0, 1'b1, 4'h0, 16'h0048, 32'h0, 1'b0, 4'h0, 16'h0, 32'h0);
    step();
    idle(); step(); step();

    // randomized traffic segments with varied request densities
    xr = 1'b0;
    for (int s = 0; s < 60; s++) begin
      int pi, pd, px;
      pi = $urandom_range(0, 100);
      pd = $urandom_range(0, 100);
      px = $urandom_range(0, 25);
      for (int c = 0; c < 40; c++) begin
        if ($urandom_range(0, 99) < px) xr = ~xr;
        set_in(1'($urandom_range(0, 199) == 0),
               1'($urandom_range(0, 99) < pi), rnd_addr(),
               1'($urandom_range(0, 99) < pd),
               ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0,
               rnd_addr(), $urandom,
               xr,
               ($urandom_range(0, 1) == 0) ? 4'($urandom_range(1, 15)) : 4'h0,
               rnd_addr(), $urandom);
        step();
      end
    end
    idle(); step(); step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
